// File: rtl/slot_reel_engine.sv
// Multi-reel slot engine: free-running per-reel LFSRs, tick-paced symbol updates,
// staggered or player-requested reel stops, then a graded match against reel 0.
module slot_reel_engine #(
  parameter int NUM_REELS   = 5,
  parameter int SYM_W       = 3,
  parameter int NUM_SYMS    = 4,
  parameter int LFSR_W      = 16,
  parameter int SPIN_CYCLES = 150_000_000,
  parameter int STOP_GAP    = 25_000_000,
  parameter int TICK_CYCLES = 500_000,
  parameter int MIN_MATCH   = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       seed_we_i,
  input  logic [LFSR_W-1:0]          seed_i,
  output logic                       busy_o,
  output logic [NUM_REELS-1:0]       reel_stopped_o,
  output logic [NUM_REELS*SYM_W-1:0] sym_o,
  output logic                       done_o,
  output logic [3:0]                 match_o,
  output logic                       pay_o,
  output logic                       win_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SPIN   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [31:0]                run_q, run_d;
  logic [31:0]                tick_q, tick_d;
  logic [NUM_REELS-1:0]       stopped_q, stopped_d;
  logic [NUM_REELS*SYM_W-1:0] sym_q, sym_d;
  logic                       done_q, done_d;
  logic [3:0]                 match_q, match_d;
  logic                       pay_q, pay_d;
  logic                       win_q, win_d;

  logic [NUM_REELS*SYM_W-1:0] mapped;
  logic [NUM_REELS-1:0]       deadline;
  logic [NUM_REELS-1:0]       low_free;
  logic [3:0]                 match_cnt;
  logic                       eq_run;

  for (genvar gi = 0; gi < NUM_REELS; gi++) begin : g_reel
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, seeded;
    logic              fb;

    assign fb     = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-3] ^ lfsr_q[LFSR_W-4] ^ lfsr_q[LFSR_W-6];
    assign seeded = seed_i ^ LFSR_W'(gi + 1);

    // A zero seed would lock the LFSR at zero forever, so it is forced to 1.
    always_comb begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
      if (state_q == S_IDLE && seed_we_i)
        lfsr_d = (seeded == '0) ? LFSR_W'(1) : seeded;
    end

    assign mapped[gi*SYM_W +: SYM_W] = SYM_W'(lfsr_q % LFSR_W'(NUM_SYMS)) + SYM_W'(1);
    assign deadline[gi] = (run_q == 32'(SPIN_CYCLES - 1 + gi * STOP_GAP));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) lfsr_q <= LFSR_W'(gi + 1);
      else       lfsr_q <= lfsr_d;
    end
  end

  // Lowest zero bit of the stopped mask: the reel a skill-stop lands on.
  assign low_free = ~stopped_q & (stopped_q + NUM_REELS'(1));

  always_comb begin
    match_cnt = 4'd1;
    eq_run    = 1'b1;
    for (int k = 1; k < NUM_REELS; k++) begin
      if (eq_run && sym_q[k*SYM_W +: SYM_W] == sym_q[SYM_W-1:0]) match_cnt = match_cnt + 4'd1;
      else eq_run = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    tick_d    = tick_q;
    stopped_d = stopped_q;
    sym_d     = sym_q;
    done_d    = 1'b0;
    match_d   = match_q;
    pay_d     = pay_q;
    win_d     = win_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_SPIN;
          run_d     = '0;
          tick_d    = '0;
          stopped_d = '0;
          match_d   = '0;
          pay_d     = 1'b0;
          win_d     = 1'b0;
        end
      end
      S_SPIN: begin
        run_d  = run_q + 32'd1;
        tick_d = (tick_q == 32'(TICK_CYCLES - 1)) ? '0 : tick_q + 32'd1;
        for (int k = 0; k < NUM_REELS; k++) begin
          if (tick_q == '0 && !stopped_q[k]) sym_d[k*SYM_W +: SYM_W] = mapped[k*SYM_W +: SYM_W];
        end
        stopped_d = stopped_q | deadline | (stop_i ? low_free : '0);
        if (&stopped_d) state_d = S_RESULT;
      end
      S_RESULT: begin
        match_d = match_cnt;
        pay_d   = (match_cnt >= 4'(MIN_MATCH));
        win_d   = (match_cnt == 4'(NUM_REELS));
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      run_q     <= '0;
      tick_q    <= '0;
      stopped_q <= '1;
      sym_q     <= {NUM_REELS{SYM_W'(1)}};
      done_q    <= 1'b0;
      match_q   <= '0;
      pay_q     <= 1'b0;
      win_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      tick_q    <= tick_d;
      stopped_q <= stopped_d;
      sym_q     <= sym_d;
      done_q    <= done_d;
      match_q   <= match_d;
      pay_q     <= pay_d;
      win_q     <= win_d;
    end
  end

  assign busy_o         = (state_q == S_SPIN) || (state_q == S_RESULT);
  assign reel_stopped_o = stopped_q;
  assign sym_o          = sym_q;
  assign done_o         = done_q;
  assign match_o        = match_q;
  assign pay_o          = pay_q;
  assign win_o          = win_q;

endmodule

// File: tb/tb_slot_reel_engine.sv
// Directed bench for slot_reel_engine: three reels, short timing, a cycle model
// for symbols plus hand-computed stop/done timing and reset values.
module tb_slot_reel_engine;

  localparam int NR = 3;
  localparam int SW = 3;
  localparam int LW = 16;
  localparam int SPIN = 20;
  localparam int GAP = 5;
  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, seed_we = 1'b0;
  logic [LW-1:0] seed = '0;

  logic busy, done, pay, win;
  logic [NR-1:0] stopped;
  logic [NR*SW-1:0] sym;
  logic [3:0] match;
  logic busy2, done2, pay2, win2;
  logic [NR-1:0] stopped2;
  logic [NR*SW-1:0] sym2;
  logic [3:0] match2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slot_reel_engine #(.NUM_REELS(NR), .SYM_W(SW), .NUM_SYMS(4), .LFSR_W(LW),
    .SPIN_CYCLES(SPIN), .STOP_GAP(GAP), .TICK_CYCLES(TICK), .MIN_MATCH(3)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .seed_we_i(seed_we),
    .seed_i(seed), .busy_o(busy), .reel_stopped_o(stopped), .sym_o(sym),
    .done_o(done), .match_o(match), .pay_o(pay), .win_o(win));

  slot_reel_engine #(.NUM_REELS(NR), .SYM_W(SW), .NUM_SYMS(1), .LFSR_W(LW),
    .SPIN_CYCLES(SPIN), .STOP_GAP(GAP), .TICK_CYCLES(TICK), .MIN_MATCH(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .seed_we_i(seed_we),
    .seed_i(seed), .busy_o(busy2), .reel_stopped_o(stopped2), .sym_o(sym2),
    .done_o(done2), .match_o(match2), .pay_o(pay2), .win_o(win2));

  // Reference model (0 idle, 1 spin, 2 result)
  logic [LW-1:0] m_lfsr [NR];
  logic [SW-1:0] m_sym [NR];
  logic [NR-1:0] m_stopped;
  int m_state, m_rc, m_match;
  logic m_done, m_pay, m_win;

  function automatic logic [SW-1:0] map_sym(input logic [LW-1:0] v);
    return SW'((v % 4) + 1);
  endfunction

  task automatic mreset();
    for (int k = 0; k < NR; k++) begin
      m_lfsr[k] = LW'(k + 1);
      m_sym[k] = SW'(1);
    end
    m_stopped = '1; m_state = 0; m_rc = 0; m_match = 0;
    m_done = 0; m_pay = 0; m_win = 0;
  endtask

  task automatic mclock();
    logic [LW-1:0] old [NR];
    logic [NR-1:0] ns;
    int st_old, cnt;
    logic run_eq, hit;
    logic [LW-1:0] v;
    st_old = m_state;
    for (int k = 0; k < NR; k++) old[k] = m_lfsr[k];
    m_done = 0;
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_rc = 0; m_stopped = '0; m_match = 0; m_pay = 0; m_win = 0;
      end
    end else if (m_state == 1) begin
      for (int k = 0; k < NR; k++)
        if ((m_rc % TICK) == 0 && !m_stopped[k]) m_sym[k] = map_sym(old[k]);
      ns = m_stopped;
      for (int k = 0; k < NR; k++) if (m_rc == SPIN - 1 + k * GAP) ns[k] = 1'b1;
      if (stop) begin
        hit = 0;
        for (int k = 0; k < NR; k++)
          if (!hit && !m_stopped[k]) begin ns[k] = 1'b1; hit = 1; end
      end
      m_stopped = ns; m_rc++;
      if (ns == '1) m_state = 2;
    end else begin
      cnt = 1; run_eq = 1;
      for (int k = 1; k < NR; k++)
        if (run_eq && m_sym[k] == m_sym[0]) cnt++; else run_eq = 0;
      m_match = cnt; m_pay = (cnt >= 3); m_win = (cnt == NR); m_done = 1; m_state = 0;
    end
    for (int k = 0; k < NR; k++) begin
      if (st_old == 0 && seed_we) begin
        v = seed ^ LW'(k + 1);
        m_lfsr[k] = (v == 0) ? LW'(1) : v;
      end else begin
        m_lfsr[k] = {old[k][14:0], old[k][15] ^ old[k][13] ^ old[k][12] ^ old[k][10]};
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) mreset(); else mclock();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return 32'({busy, stopped, sym, done, match, pay, win});
  endfunction

  function automatic logic [31:0] mod_vec();
    return 32'({(m_state != 0), m_stopped, m_sym[2], m_sym[1], m_sym[0], m_done,
                4'(m_match), m_pay, m_win});
  endfunction

  task automatic run_spin(input string name, input logic sw, input int sa, input int sb,
                          input int ra, input logic inj, input int t0, input int t1, input int t2);
    start = 1; seed_we = sw; seed = 16'h0001;
    step();
    start = 0; seed_we = 0;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      chk("model", obs_vec(), mod_vec());
      if (cyc == ra) begin
        rst = 1; #1; mreset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sym", 32'(sym), 32'h049);
        chk("rst_stopped", 32'(stopped), 32'h7);
        step(); chk("rst_hold_done", 32'(done), 32'd0);
        step(); rst = 0;
        step(); chk("post_rst", obs_vec(), mod_vec());
        chk("post_rst_done", 32'(done), 32'd0);
        $display("spin %s: reset at cycle %0d", name, ra);
        return;
      end
      chk("stopped", 32'(stopped), 32'({cyc >= t2, cyc >= t1, cyc >= t0}));
      chk("busy", 32'(busy), 32'(cyc <= 31));
      chk("done", 32'(done), 32'(cyc == 32));
      if (sw && cyc == 2) chk("seed_sym", 32'(sym), 32'h0E2);
      if (cyc == 32) begin
        chk("one_sym_sym", 32'(sym2), 32'h049);
        chk("one_sym_match", 32'(match2), 32'd3);
        chk("one_sym_pay", 32'(pay2), 32'd1);
        chk("one_sym_win", 32'(win2), 32'd1);
        $display("spin %s: sym=%h match=%0d pay=%0d win=%0d", name, sym, match, pay, win);
      end
      stop = (cyc == sa || cyc == sb);
      if (inj && (cyc == 5 || cyc == 12)) begin
        start = 1; seed_we = 1; seed = 16'hBEEF;
      end
      step();
      stop = 0; start = 0; seed_we = 0;
    end
  endtask

  initial begin
    mreset();
    step(); step();
    chk("reset_vec", obs_vec(), 32'({1'b0, 3'b111, 9'h049, 1'b0, 4'd0, 1'b0, 1'b0}));
    chk("reset_done2", 32'(done2), 32'd0);
    rst = 0;
    step(); step();
    chk("idle", obs_vec(), mod_vec());
    run_spin("A", 1'b0, -1, -1, -1, 1'b0, 21, 26, 31);
    run_spin("B", 1'b1, -1, -1, -1, 1'b0, 21, 26, 31);
    run_spin("C", 1'b1, -1, -1, -1, 1'b1, 21, 26, 31);
    step(); step(); step();
    chk("idle_hold", obs_vec(), mod_vec());
    run_spin("D", 1'b0, 3, 6, -1, 1'b0, 4, 7, 31);
    run_spin("E", 1'b0, -1, -1, 10, 1'b0, 21, 26, 31);
    run_spin("F", 1'b0, -1, -1, -1, 1'b0, 21, 26, 31);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
